// File: rtl/spi_frame_tx.sv
//------------------------------------------------------------------------------
// Module      : spi_frame_tx
// Description : SPI master transmitter for one 3-byte command frame
//               {command, databyte1, databyte2}. Mode 0, MSB first, cs is
//               active-high for the whole frame, then a fixed idle gap.
//               Optional macro SPI_TX_READBACK_EN adds an sdo input that is
//               sampled on every sck rise into rx_data.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_frame_tx #(
   parameter int CLK_DIV    = 4,   // sck half-period in clk cycles (>= 1)
   parameter int GAP_CYCLES = 8    // idle clk cycles after cs drops (>= 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  command,
   input  logic [7:0]  databyte1,
   input  logic [7:0]  databyte2,
`ifdef SPI_TX_READBACK_EN
   input  logic        sdo,
   output logic [23:0] rx_data,
`endif
   output logic        busy,
   output logic        done,
   output logic        cs,
   output logic        sck,
   output logic        sdi
);

   // One counter serves both the sck half-period and the gap wait
   localparam int c_CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

   localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(CLK_DIV - 1);
   localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(GAP_CYCLES - 1);
   localparam logic [4:0]         c_BIT_LAST = 5'd23;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [23:0]          r_shift;
   logic [23:0]          w_shift_nxt;
   logic [4:0]           r_bit_cnt;
   logic [4:0]           w_bit_nxt;
   logic [c_CNT_W-1:0]   r_div_cnt;
   logic [c_CNT_W-1:0]   w_div_nxt;
   logic                 r_cs;
   logic                 w_cs_nxt;
   logic                 r_sck;
   logic                 w_sck_nxt;
   logic                 r_sdi;
   logic                 w_sdi_nxt;
   logic                 r_busy;
   logic                 w_busy_nxt;
   logic                 r_done;
   logic                 w_done_nxt;

   // State and all output registers; reset aborts any frame without done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_div_cnt <= '0;
         r_cs      <= 1'b0;
         r_sck     <= 1'b0;
         r_sdi     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_div_cnt <= w_div_nxt;
         r_cs      <= w_cs_nxt;
         r_sck     <= w_sck_nxt;
         r_sdi     <= w_sdi_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Next-state and next-output decode; every event fires when the divide
   // counter reaches its terminal value, then the counter restarts at 0
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit_cnt;
      w_div_nxt   = r_div_cnt + c_CNT_W'(1);
      w_cs_nxt    = r_cs;
      w_sck_nxt   = r_sck;
      w_sdi_nxt   = r_sdi;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_div_nxt = '0;
            if (start) begin
               // Edge 0: latch frame, raise cs, present the first bit
               w_shift_nxt = {command, databyte1, databyte2};
               w_bit_nxt   = '0;
               w_cs_nxt    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_sdi_nxt   = command[7];
               w_state_nxt = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_nxt   = '0;
               w_sck_nxt   = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_nxt = '0;
               w_sck_nxt = ~r_sck;
               if (r_sck) begin
                  // Falling edge: the only place sdi is allowed to move
                  if (r_bit_cnt == c_BIT_LAST) begin
                     w_sdi_nxt   = 1'b0;
                     w_shift_nxt = '0;
                     w_bit_nxt   = '0;
                     w_state_nxt = ST_HOLD;
                  end else begin
                     w_sdi_nxt   = r_shift[22];
                     w_shift_nxt = {r_shift[22:0], 1'b0};
                     w_bit_nxt   = r_bit_cnt + 5'd1;
                  end
               end
            end
         end

         ST_HOLD: begin
            if (r_div_cnt == c_DIV_LAST) begin
               w_div_nxt   = '0;
               w_cs_nxt    = 1'b0;
               w_state_nxt = ST_GAP;
            end
         end

         ST_GAP: begin
            if (r_div_cnt == c_GAP_LAST) begin
               // busy drops together with done so a start seen during the
               // done cycle is accepted immediately
               w_div_nxt   = '0;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_div_nxt   = '0;
         end
      endcase
   end

`ifdef SPI_TX_READBACK_EN
   logic        w_accept;
   logic        w_sck_rise;
   logic [23:0] r_rx_data;

   assign w_accept   = (r_state == ST_IDLE) && start;
   assign w_sck_rise = ~r_sck & w_sck_nxt;

   // Capture sdo on every sck rise; cleared when a new frame is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_data <= '0;
      end else if (w_accept) begin
         r_rx_data <= '0;
      end else if (w_sck_rise) begin
         r_rx_data <= {r_rx_data[22:0], sdo};
      end
   end

   assign rx_data = r_rx_data;
`endif

   assign busy = r_busy;
   assign done = r_done;
   assign cs   = r_cs;
   assign sck  = r_sck;
   assign sdi  = r_sdi;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_spi_frame_tx
// Description : Scoreboard bench for spi_frame_tx. Two instances: defaults
//               (CLK_DIV=4, GAP_CYCLES=8) and fast (CLK_DIV=1, GAP_CYCLES=1).
//               Stimulus pushes expected frames; a receiver-model monitor
//               decodes cs/sck/sdi and pops/compares at each frame end.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_frame_tx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  start = 2'b00;
   logic [7:0]  command = 8'h00;
   logic [7:0]  databyte1 = 8'h00;
   logic [7:0]  databyte2 = 8'h00;
   logic [1:0]  busy, done, cs, sck, sdi;
`ifdef SPI_TX_READBACK_EN
   logic [23:0] rx_data0, rx_data1;
`endif

   always #5 clk = ~clk;

   spi_frame_tx #(.CLK_DIV(4), .GAP_CYCLES(8)) dut0 (
      .clk(clk), .reset(reset), .start(start[0]),
      .command(command), .databyte1(databyte1), .databyte2(databyte2),
`ifdef SPI_TX_READBACK_EN
      .sdo(sdi[0]), .rx_data(rx_data0),
`endif
      .busy(busy[0]), .done(done[0]), .cs(cs[0]), .sck(sck[0]), .sdi(sdi[0])
   );

   spi_frame_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(start[1]),
      .command(command), .databyte1(databyte1), .databyte2(databyte2),
`ifdef SPI_TX_READBACK_EN
      .sdo(sdi[1]), .rx_data(rx_data1),
`endif
      .busy(busy[1]), .done(done[1]), .cs(cs[1]), .sck(sck[1]), .sdi(sdi[1])
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] exp_q[$];
   int          exp_done [2] = '{0, 0};

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int gap_of(input int i);
      return (i == 0) ? 8 : 1;
   endfunction

   // Receiver model: one per instance, sampled on the falling clk edge
   int          mon_t      [2];
   int          mon_fall_t [2];
   int          mon_rises  [2];
   logic [23:0] mon_bits   [2];
   bit          mon_active [2] = '{0, 0};
   logic        prev_cs    [2] = '{0, 0};
   logic        prev_sck   [2] = '{0, 0};
   logic        prev_done  [2] = '{0, 0};
   int          done_cnt   [2] = '{0, 0};
   int          sck_idle_err = 0;
   int          dbl_done_err = 0;

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mon_active[i] = 0;
         end else begin
            if (cs[i] && !prev_cs[i]) begin
               mon_active[i] = 1;
               mon_t[i]      = 0;
               mon_rises[i]  = 0;
               mon_bits[i]   = '0;
            end else begin
               mon_t[i]++;
            end
            if (!cs[i] && sck[i]) sck_idle_err++;
            if (mon_active[i] && cs[i] && sck[i] && !prev_sck[i]) begin
               mon_bits[i] = {mon_bits[i][22:0], sdi[i]};
               mon_rises[i]++;
            end
            if (mon_active[i] && !cs[i] && prev_cs[i]) begin
               mon_fall_t[i] = mon_t[i];
               check($sformatf("cs_high_len[%0d]", i), mon_t[i], 49 * div_of(i));
               check($sformatf("sck_rises[%0d]", i), mon_rises[i], 24);
               check($sformatf("sdi_idle[%0d]", i), sdi[i], 0);
               if (exp_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL frame_data[%0d]: got 0x%06h, expected no frame", i, mon_bits[i]);
               end else begin
                  check($sformatf("frame_data[%0d]", i), mon_bits[i], exp_q.pop_front());
               end
            end
            if (done[i]) begin
               done_cnt[i]++;
               if (prev_done[i]) dbl_done_err++;
               if (mon_active[i]) begin
                  check($sformatf("done_edge[%0d]", i), mon_t[i], 49 * div_of(i) + gap_of(i));
                  check($sformatf("cs_low_gap[%0d]", i), mon_t[i] - mon_fall_t[i], gap_of(i));
                  mon_active[i] = 0;
               end
            end
         end
         prev_cs[i]   = cs[i];
         prev_sck[i]  = sck[i];
         prev_done[i] = done[i];
      end
   end

   // Issue one frame on instance i; called on a falling clk edge
   task automatic send(input int i, input logic [23:0] f);
      {command, databyte1, databyte2} = f;
      start[i] = 1'b1;
      exp_q.push_back(f);
      exp_done[i]++;
      @(negedge clk);
      start[i] = 1'b0;
      check($sformatf("busy_on_accept[%0d]", i), busy[i], 1);
   endtask

   task automatic wait_done(input int i);
      bit seen = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (done[i]) begin
            seen = 1;
            break;
         end
      end
      check($sformatf("done_seen[%0d]", i), seen, 1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outs0", {cs[0], sck[0], sdi[0], busy[0], done[0]}, 0);
      check("reset_outs1", {cs[1], sck[1], sdi[1], busy[1], done[1]}, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Basic frame
      send(0, 24'hA53C0F);
      wait_done(0);
      repeat (3) @(negedge clk);

      // Starts while busy are ignored (edges 50 and 150)
      send(0, 24'hA53C0F);
      repeat (49) @(negedge clk);
      {command, databyte1, databyte2} = 24'h777777;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (99) @(negedge clk);
      {command, databyte1, databyte2} = 24'h999999;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0);
      repeat (3) @(negedge clk);

      // Back-to-back frames with start held high
      {command, databyte1, databyte2} = 24'h010203;
      start[0] = 1'b1;
      exp_q.push_back(24'h010203);
      exp_done[0]++;
      @(negedge clk);
      check("b2b_busy_first", busy[0], 1);
      {command, databyte1, databyte2} = 24'hFF0080;
      exp_q.push_back(24'hFF0080);
      exp_done[0]++;
      wait_done(0);
      @(negedge clk);
      check("b2b_cs_after_done", {cs[0], busy[0]}, 2'b11);
      start[0] = 1'b0;
      wait_done(0);
      repeat (3) @(negedge clk);

      // Asynchronous reset at edge 100 of a frame
      send(0, 24'h123456);
      repeat (99) @(negedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("abort_outs", {cs[0], sck[0], sdi[0], busy[0]}, 0);
      void'(exp_q.pop_back());
      exp_done[0]--;
      repeat (3) @(negedge clk);
      check("abort_no_done", done[0], 0);
      reset = 1'b0;
      @(negedge clk);
      send(0, 24'hC0FFEE);
      wait_done(0);
      repeat (3) @(negedge clk);

      // Fast instance: CLK_DIV=1, GAP_CYCLES=1
      send(1, 24'h55AA00);
      wait_done(1);
      repeat (3) @(negedge clk);

`ifdef SPI_TX_READBACK_EN
      // Loopback readback of the transmitted frame
      send(0, 24'hDEADBE);
      wait_done(0);
      check("rx_data_done", rx_data0, 24'hDEADBE);
      send(0, 24'h000001);
      check("rx_data_clear", rx_data0, 0);
      wait_done(0);
      check("rx_data_done2", rx_data0, 24'h000001);
      repeat (3) @(negedge clk);
`endif

      check("done_count0", done_cnt[0], exp_done[0]);
      check("done_count1", done_cnt[1], exp_done[1]);
      check("sck_while_cs_low", sck_idle_err, 0);
      check("done_multi_cycle", dbl_done_err, 0);
      check("frames_left", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
